// File: rtl/seq_sub_pkg.sv
// Shared constants and state encoding for the sliced sequential subtractor.
package seq_sub_pkg;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned SLICE  = 8;
   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/sub_slice8.sv
// 8-bit subtract slice: d = x - y - borrow, done as x + ~y + ~borrow.
module sub_slice8 (
   input  logic [7:0] x_i,
   input  logic [7:0] y_i,
   input  logic       borrow_i,
   output logic [7:0] d_o,
   output logic       borrow_o
);

   logic [8:0] sum;

   assign sum      = {1'b0, x_i} + {1'b0, ~y_i} + {8'd0, ~borrow_i};
   assign d_o      = sum[7:0];
   assign borrow_o = ~sum[8];

endmodule

// File: rtl/seq_subtractor32.sv
// Multi-cycle subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB slice first.
module seq_subtractor32
   import seq_sub_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o,
   output logic             ovf_o
);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, diff_q;
   logic             borrow_q, a_msb_q, b_msb_q, bout_q, ovf_q;

   logic [SLICE-1:0] slice_d;
   logic             slice_bout;
   logic [WIDTH-1:0] diff_next;

   // Operands shift right each cycle so the active slice is always the low byte.
   sub_slice8 u_slice (
      .x_i      (a_q[SLICE-1:0]),
      .y_i      (b_q[SLICE-1:0]),
      .borrow_i (borrow_q),
      .d_o      (slice_d),
      .borrow_o (slice_bout)
   );

   assign diff_next = {slice_d, acc_q[WIDTH-1:SLICE]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         borrow_q <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  state_q  <= StRun;
                  idx_q    <= '0;
                  a_q      <= a_i;
                  b_q      <= b_i;
                  acc_q    <= '0;
                  borrow_q <= bin_i;
                  a_msb_q  <= a_i[WIDTH-1];
                  b_msb_q  <= b_i[WIDTH-1];
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               a_q      <= a_q >> SLICE;
               b_q      <= b_q >> SLICE;
               acc_q    <= diff_next;
               borrow_q <= slice_bout;
               idx_q    <= idx_q + 1'b1;
               if (idx_q == IDX_W'(NSLICE - 1)) begin
                  state_q <= StDone;
                  diff_q  <= diff_next;
                  bout_q  <= slice_bout;
                  ovf_q   <= (a_msb_q != b_msb_q) && (diff_next[WIDTH-1] != a_msb_q);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o = (state_q == StRun);
   assign done_o = (state_q == StDone);
   assign diff_o = diff_q;
   assign bout_o = bout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_subtractor32.sv
// Scoreboard bench for seq_subtractor32 with directed, hand-computed vectors.
module tb_seq_subtractor32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        bin_i = 1'b0;
   logic        busy_o, done_o, bout_o, ovf_o;
   logic [31:0] diff_o;

   typedef struct packed {
      logic [31:0] d;
      logic        bo;
      logic        ov;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_subtractor32 dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .bin_i   (bin_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .diff_o  (diff_o),
      .bout_o  (bout_o),
      .ovf_o   (ovf_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic bo, input logic ov);
      exp_t e;
      e.d  = d;
      e.bo = bo;
      e.ov = ov;
      exp_q.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("diff", diff_o, e.d);
            chk("bout", {31'd0, bout_o}, {31'd0, e.bo});
            chk("ovf", {31'd0, ovf_o}, {31'd0, e.ov});
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         input logic [31:0] ed, input logic eb, input logic eo);
      int n_busy;
      bit got;
      @(negedge clk);
      a_i = a; b_i = b; bin_i = bi; start_i = 1'b1;
      push(ed, eb, eo);
      @(negedge clk);
      start_i = 1'b0;
      n_busy = 0;
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
         if (done_o) got = 1'b1;
         else begin
            if (busy_o) n_busy++;
            @(negedge clk);
         end
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      chk("busy_cycles", n_busy, 32'd4);
   endtask

   logic [31:0] a_tab[10];
   logic [31:0] b_tab[10];
   int done_at;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_diff", diff_o, 32'd0);
      chk("rst_bout", {31'd0, bout_o}, 32'd0);
      chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
      rst = 1'b0;

      run_op(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
      run_op(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      run_op(32'h0100_0000, 32'd1, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

      // Start held high: accepted from IDLE, then again in the DONE cycle.
      for (int i = 0; i < 10; i++) begin
         a_tab[i] = 32'hDEAD_0000 + i;
         b_tab[i] = 32'h0000_0100 + i;
      end
      a_tab[0] = 32'h0000_0010; b_tab[0] = 32'h0000_0001;
      a_tab[5] = 32'h7FFF_FFFF; b_tab[5] = 32'hFFFF_FFFF;
      push(32'h0000_000F, 1'b0, 1'b0);
      push(32'h8000_0000, 1'b1, 1'b1);
      done_at = -1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (done_o && done_at < 0) done_at = i;
         start_i = 1'b1; a_i = a_tab[i]; b_i = b_tab[i]; bin_i = 1'b0;
      end
      @(negedge clk);
      start_i = 1'b0;
      chk("b2b_first_done_at", done_at, 32'd5);
      chk("b2b_second_done", {31'd0, done_o}, 32'd1);

      // Start pulses and operand changes during RUN are ignored; outputs hold.
      @(negedge clk);
      a_i = 32'd100; b_i = 32'd1; bin_i = 1'b0; start_i = 1'b1;
      push(32'd99, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start_i = (k < 3);
         a_i = 32'hFFFF_0000 + k; b_i = 32'h0000_1234; bin_i = 1'b1;
         chk("hold_busy", {31'd0, busy_o}, 32'd1);
         chk("hold_diff", diff_o, 32'h8000_0000);
         chk("hold_bout", {31'd0, bout_o}, 32'd1);
         chk("hold_ovf", {31'd0, ovf_o}, 32'd1);
      end
      @(negedge clk);
      start_i = 1'b0;
      chk("hold_done", {31'd0, done_o}, 32'd1);

      // Reset during the second RUN cycle aborts without a done pulse.
      @(negedge clk);
      a_i = 32'h0000_AAAA; b_i = 32'd1; bin_i = 1'b0; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_done", {31'd0, done_o}, 32'd0);
      chk("abort_diff", diff_o, 32'd0);
      chk("abort_bout", {31'd0, bout_o}, 32'd0);
      chk("abort_ovf", {31'd0, ovf_o}, 32'd0);
      repeat (6) @(negedge clk);
      run_op(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation reached %0t without completing", $time);
      $fatal(1, "timeout");
   end

endmodule
